soc_gpio_top: RTL and testbench
===============================

// Module: soc_gpio_top
// PURPOSE
//  Minimal SoC top: a simple single-cycle bus master port decoded to an on-chip word RAM and a 32-bit GPIO block.
//  Integrated as the top-level peripheral subsystem.
//  External bus agents (CPU or testbench) access it through one flat 32-bit address map.
//  GPIO output pins are gated by a per-bit direction register.
// PARAMETERS
//  GPIO_BASE   32'h4000_0000  base of GPIO register window (4 KB, addr[31:12] match)
//  RAM_BASE    32'h0000_0000  base of word RAM window (addr[31:12] match)
//  RAM_WORDS   256            RAM depth in 32-bit words; power of 2, <= 1024
// PORTS
//  clk        in   1   single system clock, all logic on rising edge
//  rst_n      in   1   synchronous reset, ACTIVE-HIGH (name kept for integration); sampled on clk
//  bus_wr_en  in   1   write strobe, one write per cycle asserted
//  bus_rd_en  in   1   read strobe, one read per cycle asserted
//  bus_addr   in   32  byte address; bits [1:0] ignored (word access only)
//  bus_wdata  in   32  write data
//  bus_rdata  out  32  registered read data
//  gpio_in    in   32  asynchronous input pins
//  gpio_out   out  32  output pins
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset (rst_n=1 at a clk edge): DATA=0, DIR=0, bus_rdata=0, sync flops=0, gpio_out=0; RAM contents not reset; bus ignored.
//  GPIO register map (offset from GPIO_BASE, addr[11:2]):
//   0x00 DATA  RW  output data latch
//   0x04 IN    RO  gpio_in after 2-flop synchronizer; writes ignored
//   0x08 DIR   RW  1=output, 0=input (per bit)
//   0x0C SET   WO  DATA <= DATA | wdata; reads return 0
//   0x10 CLR   WO  DATA <= DATA & ~wdata; reads return 0
//   other offsets: writes ignored, reads return 0
//  gpio_out = DATA & DIR, combinational from registers; changes the cycle after the write edge.
//  Writes: take effect at the rising edge where bus_wr_en=1; no wait states.
//  Reads: bus_rd_en=1 at edge N -> bus_rdata valid after edge N (1-cycle latency) and held until next read or reset.
//  Read/write same cycle: write commits, read returns pre-write value (read-before-write) for RAM and GPIO.
//  IN latency: gpio_in change visible in IN after 2 edges, readable on bus_rdata after 3.
//  RAM: index = addr[log2(RAM_WORDS)+1:2]; addresses beyond depth inside the 4 KB window alias (wrap).
//  Unmapped address (neither window): write dropped, read returns 32'h0000_0000.
//  No error/ready signalling; back-to-back accesses every cycle supported.
// STRUCTURE
//  Package soc_pkg: GPIO_BASE/RAM_BASE defaults, register offset constants (OFF_DATA, OFF_IN, OFF_DIR, OFF_SET, OFF_CLR).
//  Sub-module gpio_regs: DATA/DIR/synchronizer, SET/CLR, readback mux.
//  Top contains address decode, RAM array, rdata mux/register.
// TESTING
//  1. Reset held 2 cycles -> gpio_out=0, bus_rdata=0; read DIR -> 0.
//  2. Write DIR=FFFF_FFFF, DATA=A5A5_A5A5 -> gpio_out=A5A5_A5A5 one cycle after DATA write; read DATA -> A5A5_A5A5.
//  3. DIR=0000_FFFF, DATA=A5A5_A5A5 -> gpio_out=0000_A5A5; SET 0000_0002 -> gpio_out=0000_A5A7; CLR 0000_0005 -> 0000_A5A2.
//  4. gpio_in=1234_5678, wait 3 cycles, read 0x4000_0004 -> 1234_5678; write IN=FFFF_FFFF -> read unchanged.
//  5. RAM write 0x10=DEAD_BEEF, read 0x10 -> DEAD_BEEF; simultaneous wr 0x10=1 + rd 0x10 -> DEAD_BEEF, next read -> 1.
//  6. Read 0x8000_0000 -> 0; reset mid-run after DATA write -> gpio_out=0, DIR=0 next cycle.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared constants for the SoC peripheral subsystem: default window bases,
// GPIO register offsets and the register-select decode.
package soc_pkg;

   localparam logic [31:0] DEF_GPIO_BASE = 32'h4000_0000;
   localparam logic [31:0] DEF_RAM_BASE  = 32'h0000_0000;

   localparam logic [11:0] OFF_DATA = 12'h000;
   localparam logic [11:0] OFF_IN   = 12'h004;
   localparam logic [11:0] OFF_DIR  = 12'h008;
   localparam logic [11:0] OFF_SET  = 12'h00C;
   localparam logic [11:0] OFF_CLR  = 12'h010;

   typedef enum logic [2:0] {
      REG_DATA,
      REG_IN,
      REG_DIR,
      REG_SET,
      REG_CLR,
      REG_NONE
   } gpio_reg_e;

   // Word index within the 4 KB window; byte lane bits are already dropped.
   function automatic gpio_reg_e decodeReg(input logic [9:0] wordIdx);
      gpio_reg_e sel;
      case (wordIdx)
         OFF_DATA[11:2]: sel = REG_DATA;
         OFF_IN[11:2]:   sel = REG_IN;
         OFF_DIR[11:2]:  sel = REG_DIR;
         OFF_SET[11:2]:  sel = REG_SET;
         OFF_CLR[11:2]:  sel = REG_CLR;
         default:        sel = REG_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/gpio_regs.sv
// GPIO register block: DATA/DIR latches, SET/CLR helpers, a 2-flop input
// synchronizer and the combinational readback mux.
module gpio_regs
   import soc_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wrEn_i,
   input  logic [9:0]  regIdx_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] gpioIn_i,
   output logic [31:0] rdata_o,
   output logic [31:0] gpioOut_o
);

   gpio_reg_e   sel;
   logic [31:0] data_q, data_d;
   logic [31:0] dir_q, dir_d;
   logic [31:0] sync1_q, sync2_q;

   assign sel = decodeReg(regIdx_i);

   always_comb begin
      data_d = data_q;
      dir_d  = dir_q;
      if (wrEn_i) begin
         case (sel)
            REG_DATA: data_d = wdata_i;
            REG_DIR:  dir_d  = wdata_i;
            REG_SET:  data_d = data_q | wdata_i;
            REG_CLR:  data_d = data_q & ~wdata_i;
            default:  ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q  <= '0;
         dir_q   <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         data_q  <= data_d;
         dir_q   <= dir_d;
         sync1_q <= gpioIn_i;
         sync2_q <= sync1_q;
      end
   end

   // Readback reflects register state before any write at the same edge.
   always_comb begin
      case (sel)
         REG_DATA: rdata_o = data_q;
         REG_IN:   rdata_o = sync2_q;
         REG_DIR:  rdata_o = dir_q;
         default:  rdata_o = '0;
      endcase
   end

   assign gpioOut_o = data_q & dir_q;

endmodule

// File: rtl/soc_gpio_top.sv
// Peripheral subsystem top: decodes a single-cycle bus into a word RAM and
// the GPIO register block, with a registered read-data path.
module soc_gpio_top
   import soc_pkg::*;
#(
   parameter logic [31:0] GPIO_BASE = DEF_GPIO_BASE,
   parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
   parameter int          RAM_WORDS = 256
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bus_wr_en,
   input  logic        bus_rd_en,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   input  logic [31:0] gpio_in,
   output logic [31:0] gpio_out
);

   localparam int AW = $clog2(RAM_WORDS);

   logic          ramSel, gpioSel;
   logic [AW-1:0] ramIdx;
   logic [31:0]   ram [RAM_WORDS];
   logic [31:0]   gpioRdata;
   logic [31:0]   rdata_q, rdata_d;
   logic [1:0]    unused_addr_bits;

   assign unused_addr_bits = bus_addr[1:0];

   assign ramSel  = (bus_addr[31:12] == RAM_BASE[31:12]);
   assign gpioSel = (bus_addr[31:12] == GPIO_BASE[31:12]) && !ramSel;
   assign ramIdx  = bus_addr[AW+1:2];

   gpio_regs uGpio (
      .clk_i     (clk),
      .rst_i     (rst_n),
      .wrEn_i    (bus_wr_en && gpioSel),
      .regIdx_i  (bus_addr[11:2]),
      .wdata_i   (bus_wdata),
      .gpioIn_i  (gpio_in),
      .rdata_o   (gpioRdata),
      .gpioOut_o (gpio_out)
   );

   // RAM has no reset; writes are still blocked while reset is asserted.
   always_ff @(posedge clk) begin
      if (!rst_n && bus_wr_en && ramSel) begin
         ram[ramIdx] <= bus_wdata;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (bus_rd_en) begin
         if (ramSel) begin
            rdata_d = ram[ramIdx];
         end else if (gpioSel) begin
            rdata_d = gpioRdata;
         end else begin
            rdata_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign bus_rdata = rdata_q;

endmodule

// File: tb/tb_soc_gpio_top.sv
// Self-checking bench for soc_gpio_top: directed scenarios followed by random
// bus traffic compared against a behavioural model of the address map.
module tb_soc_gpio_top;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        bus_wr_en;
   logic        bus_rd_en;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic [31:0] gpio_in;
   logic [31:0] gpio_out;

   int assertions = 0;
   int failures   = 0;

   logic [31:0] ramModel [256];
   logic [31:0] dataModel;
   logic [31:0] dirModel;
   logic [31:0] rdataModel;
   logic [31:0] pinHist [$];

   soc_gpio_top dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus_wr_en (bus_wr_en),
      .bus_rd_en (bus_rd_en),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .gpio_in   (gpio_in),
      .gpio_out  (gpio_out)
   );

   always #5 clk = ~clk;

   // Behavioural view of the address map: what a read returns right now.
   function automatic logic [31:0] modelRead(input logic [31:0] addr);
      logic [31:0] value;
      int          off;
      value = 32'h0;
      off   = int'((addr >> 2) & 32'h3FF);
      if ((addr >> 12) == 32'h0) begin
         value = ramModel[(addr >> 2) % 256];
      end else if ((addr >> 12) == 32'h0004_0000) begin
         if (off == 0)      value = dataModel;
         else if (off == 1) value = pinHist[0];
         else if (off == 2) value = dirModel;
      end
      return value;
   endfunction

   task automatic modelWrite(input logic [31:0] addr, input logic [31:0] wdata);
      int off;
      off = int'((addr >> 2) & 32'h3FF);
      if ((addr >> 12) == 32'h0) begin
         ramModel[(addr >> 2) % 256] = wdata;
      end else if ((addr >> 12) == 32'h0004_0000) begin
         if (off == 0)      dataModel = wdata;
         else if (off == 2) dirModel  = wdata;
         else if (off == 3) dataModel = dataModel | wdata;
         else if (off == 4) dataModel = dataModel & ~wdata;
      end
   endtask

   // One bus cycle: drive, advance the model at the edge, release strobes.
   task automatic applyStimulus(input logic rst, input logic wr, input logic rd,
                                input logic [31:0] addr, input logic [31:0] wdata);
      rst_n     = rst;
      bus_wr_en = wr;
      bus_rd_en = rd;
      bus_addr  = addr;
      bus_wdata = wdata;
      @(posedge clk);
      if (rst) begin
         dataModel  = 32'h0;
         dirModel   = 32'h0;
         rdataModel = 32'h0;
         pinHist.delete();
         pinHist.push_back(32'h0);
         pinHist.push_back(32'h0);
      end else begin
         if (rd) rdataModel = modelRead(addr);
         if (wr) modelWrite(addr, wdata);
         pinHist.push_back(gpio_in);
         void'(pinHist.pop_front());
      end
      #1;
      rst_n     = 1'b0;
      bus_wr_en = 1'b0;
      bus_rd_en = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertions++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, "_rdata"}, bus_rdata, rdataModel);
      checkOutput({tag, "_gpio_out"}, gpio_out, dataModel & dirModel);
   endtask

   initial begin
      logic [31:0] rnd;
      logic [31:0] addr;
      logic        wr, rd, rst;

      rst_n     = 1'b1;
      bus_wr_en = 1'b0;
      bus_rd_en = 1'b0;
      bus_addr  = 32'h0;
      bus_wdata = 32'h0;
      gpio_in   = 32'h0;
      $display("[TB] start");

      // Reset for two cycles
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("reset_gpio_out", gpio_out, 32'h0);
      checkOutput("reset_rdata", bus_rdata, 32'h0);

      // Give every RAM word a known value so later reads are defined
      for (int i = 0; i < 256; i++) begin
         rnd = $urandom;
         applyStimulus(1'b0, 1'b1, 1'b0, 32'(i * 4), rnd);
      end

      applyStimulus(1'b0, 1'b0, 1'b1, 32'h4000_0008, 32'h0);
      checkOutput("reset_dir_read", bus_rdata, 32'h0);

      // Full output direction then DATA
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h4000_0008, 32'hFFFF_FFFF);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h4000_0000, 32'hA5A5_A5A5);
      checkOutput("data_out_all", gpio_out, 32'hA5A5_A5A5);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'h0);
      checkOutput("data_read", bus_rdata, 32'hA5A5_A5A5);

      // Partial direction mask, SET and CLR
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h4000_0008, 32'h0000_FFFF);
      checkOutput("dir_mask", gpio_out, 32'h0000_A5A5);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h4000_000C, 32'h0000_0002);
      checkOutput("set_bit", gpio_out, 32'h0000_A5A7);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h4000_0010, 32'h0000_0005);
      checkOutput("clr_bits", gpio_out, 32'h0000_A5A2);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h4000_000C, 32'h0);
      checkOutput("set_reads_zero", bus_rdata, 32'h0);

      // Input synchronizer latency and read-only IN
      gpio_in = 32'h1234_5678;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h4000_0004, 32'h0);
      checkOutput("in_sync_read", bus_rdata, 32'h1234_5678);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h4000_0004, 32'hFFFF_FFFF);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h4000_0004, 32'h0);
      checkOutput("in_write_ignored", bus_rdata, 32'h1234_5678);

      // RAM read-before-write and aliasing
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
      checkOutput("ram_read", bus_rdata, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h0000_0001);
      checkOutput("ram_rbw", bus_rdata, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0000_0010, 32'h0);
      checkOutput("rdata_hold", bus_rdata, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
      checkOutput("ram_after_rbw", bus_rdata, 32'h0000_0001);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0410, 32'h0BAD_F00D);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0010, 32'h0);
      checkOutput("ram_alias", bus_rdata, 32'h0BAD_F00D);

      // Unmapped read, then reset in the middle of activity
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h0);
      checkOutput("unmapped_read", bus_rdata, 32'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h4000_0000, 32'h0000_00FF);
      checkOutput("data_before_reset", gpio_out, 32'h0000_00FF);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h4000_0008, 32'hFFFF_FFFF);
      checkOutput("midrun_reset_out", gpio_out, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h4000_0008, 32'h0);
      checkOutput("midrun_reset_dir", bus_rdata, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h4000_0000, 32'h0);
      checkOutput("midrun_reset_data", bus_rdata, 32'h0);

      // Random traffic across RAM, GPIO and unmapped space
      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 3))
            0:       addr = $urandom & 32'h0000_0FFF;
            1, 2:    addr = 32'h4000_0000 | (32'($urandom_range(0, 7)) << 2);
            default: addr = $urandom | 32'h8000_0000;
         endcase
         wr  = 1'($urandom_range(0, 1));
         rd  = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 3) == 0) gpio_in = $urandom;
         rnd = $urandom;
         applyStimulus(rst, wr, rd, addr, rnd);
         checkModel("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
